// File: rtl/seq_det_pkg.sv
// Shared types and defaults for the serial sequence detector.
package seq_det_pkg;

  localparam int W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CFG  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/seq_det_match.sv
// Serial shift register, valid-bit counter and pattern comparator.
// hit is combinational and describes the bit being sampled on the
// current edge, so the caller can register a pulse with latency 1.
module seq_det_match
  import seq_det_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         shift_en,
  input  logic         x,
  input  logic [W-1:0] pattern,
  input  logic [2:0]   len,
  input  logic         overlap,
  output logic         hit
);

  logic [W-1:0] sr;
  logic [W-1:0] sr_next;
  logic [W-1:0] mask;
  logic [3:0]   vcnt;
  logic [3:0]   vcnt_next;
  logic [3:0]   need;

  // Next shift value, saturating bit count and masked compare.
  always_comb begin
    need      = {1'b0, len} + 4'd1;
    sr_next   = {sr[W-2:0], x};
    vcnt_next = (vcnt >= need) ? vcnt : vcnt + 4'd1;
    mask      = '0;
    for (int i = 0; i < W; i++) begin
      mask[i] = (i <= int'(len));
    end
    hit = (vcnt_next >= need) && (((sr_next ^ pattern) & mask) == '0);
  end

  // Shift in one bit per enabled cycle; non-overlap mode forgets the
  // bits consumed by a match so they cannot start the next one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr   <= '0;
      vcnt <= '0;
    end else if (clear) begin
      sr   <= '0;
      vcnt <= '0;
    end else if (shift_en) begin
      sr   <= sr_next;
      vcnt <= (hit && !overlap) ? 4'd0 : vcnt_next;
    end
  end

endmodule

// File: rtl/seq_det_ctrl.sv
// Configurable serial pattern detector: config handshake, run control,
// match pulse and match counter.
// Handshake: a configuration transfers on a rising clk edge where
// cfg_valid & cfg_ready are both high; cfg_ready depends only on state.
module seq_det_ctrl
  import seq_det_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cfg_valid,
  output logic         cfg_ready,
  input  logic [W-1:0] cfg_pattern,
  input  logic [2:0]   cfg_len,
  input  logic         cfg_overlap,
  input  logic [3:0]   cfg_max,
  input  logic         start,
  input  logic         abort,
  input  logic         x,
  output logic         z,
  output logic [3:0]   match_cnt,
  output logic         busy,
  output logic         done
);

  state_t       state, state_d;
  logic [W-1:0] pattern_q, pattern_d;
  logic [2:0]   len_q, len_d;
  logic         overlap_q, overlap_d;
  logic [3:0]   max_q, max_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         z_q, z_d;
  logic         clear_m;
  logic         shift_en;
  logic         hit;

  seq_det_match #(.W(W)) u_match (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear_m),
    .shift_en (shift_en),
    .x        (x),
    .pattern  (pattern_q),
    .len      (len_q),
    .overlap  (overlap_q),
    .hit      (hit)
  );

  // State, configuration, counter and pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pattern_q <= '0;
      len_q     <= '0;
      overlap_q <= 1'b0;
      max_q     <= '0;
      cnt_q     <= '0;
      z_q       <= 1'b0;
    end else begin
      state     <= state_d;
      pattern_q <= pattern_d;
      len_q     <= len_d;
      overlap_q <= overlap_d;
      max_q     <= max_d;
      cnt_q     <= cnt_d;
      z_q       <= z_d;
    end
  end

  // Next-state logic; a config handshake outranks start, abort outranks a match.
  always_comb begin
    state_d   = state;
    pattern_d = pattern_q;
    len_d     = len_q;
    overlap_d = overlap_q;
    max_d     = max_q;
    cnt_d     = cnt_q;
    z_d       = 1'b0;
    clear_m   = 1'b0;
    shift_en  = 1'b0;
    case (state)
      IDLE: begin
        if (cfg_valid) begin
          pattern_d = cfg_pattern;
          len_d     = cfg_len;
          overlap_d = cfg_overlap;
          max_d     = cfg_max;
          state_d   = CFG;
        end
      end
      CFG, DONE: begin
        if (cfg_valid) begin
          pattern_d = cfg_pattern;
          len_d     = cfg_len;
          overlap_d = cfg_overlap;
          max_d     = cfg_max;
          state_d   = CFG;
        end else if (start) begin
          clear_m = 1'b1;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = CFG;
        end else begin
          shift_en = 1'b1;
          if (hit) begin
            z_d = 1'b1;
            if (cnt_q != 4'd15) cnt_d = cnt_q + 4'd1;
            if ((max_q != 4'd0) && ((cnt_q + 4'd1) == max_q)) state_d = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign z         = z_q;
  assign match_cnt = cnt_q;
  assign busy      = (state == RUN);
  assign done      = (state == DONE);
  assign cfg_ready = (state != RUN);

endmodule
